loadstore_queue: RTL

LOADSTORE_QUEUE -- requirements
Module: loadstore_queue

---
 rtl/loadstore_queue.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/loadstore_queue.sv
// loadstore_queue: in-order load/store unit between the execute stage and a
// simple memory port.
//
// Request side : i_req_valid/o_req_ready, i_is_store, i_funct3, i_imm,
//                i_op0 (base), i_op1 (store data), i_rd (load tag).
// Memory side  : o_mem_valid/i_mem_ready, o_mem_cmd, o_mem_addr, o_mem_be,
//                o_mem_data; in-order responses i_mem_rvalid/i_mem_rdata.
// Writeback    : o_ld_valid, o_ld_data, o_ld_rd.
// Exception    : o_misalign, o_misalign_addr (one-cycle pulse).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid source holds its payload until the transfer happens,
// and ready never depends on valid. i_mem_rvalid has no back-pressure.
//
// Requests are computed (address, byte enables, lane-aligned data) on
// acceptance and stored in a request FIFO. Issued loads are remembered in a
// pending-load FIFO so each response can be shifted and extended for its
// own size and offset.
module loadstore_queue #(
  parameter int DEPTH = 4,
  parameter int RDW   = 5
) (
  input  logic           clk,
  input  logic           aresetn,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  logic           i_is_store,
  input  logic [2:0]     i_funct3,
  input  logic [11:0]    i_imm,
  input  logic [31:0]    i_op0,
  input  logic [31:0]    i_op1,
  input  logic [RDW-1:0] i_rd,
  output logic           o_mem_valid,
  input  logic           i_mem_ready,
  output logic           o_mem_cmd,
  output logic [31:0]    o_mem_addr,
  output logic [3:0]     o_mem_be,
  output logic [31:0]    o_mem_data,
  input  logic           i_mem_rvalid,
  input  logic [31:0]    i_mem_rdata,
  output logic           o_ld_valid,
  output logic [31:0]    o_ld_data,
  output logic [RDW-1:0] o_ld_rd,
  output logic           o_misalign,
  output logic [31:0]    o_misalign_addr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------- request decode ----------------
  logic [31:0] addr;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] sdata;
  logic        misaligned;
  logic        accept;

  assign addr = i_op0 + {{20{i_imm[11]}}, i_imm};
  assign off  = addr[1:0];

  // funct3[1:0] == 3 falls into the WORD branch.
  always_comb begin
    be         = 4'b1111;
    sdata      = i_op1;
    misaligned = 1'b0;
    case (i_funct3[1:0])
      2'd0: begin
        be    = 4'b0001 << off;
        sdata = {24'b0, i_op1[7:0]} << {off, 3'b000};
      end
      2'd1: begin
        be         = 4'b0011 << off;
        sdata      = {16'b0, i_op1[15:0]} << {off, 3'b000};
        misaligned = off[0];
      end
      default: misaligned = (off != 2'b00);
    endcase
    if (!i_is_store) sdata = '0;
  end

  // ---------------- request FIFO ----------------
  logic           rq_cmd  [DEPTH];
  logic [31:0]    rq_addr [DEPTH];
  logic [3:0]     rq_be   [DEPTH];
  logic [31:0]    rq_data [DEPTH];
  logic [2:0]     rq_f3   [DEPTH];
  logic [RDW-1:0] rq_rd   [DEPTH];
  logic [AW-1:0]  rq_head, rq_tail;
  logic [CW-1:0]  rq_cnt;
  logic           rq_empty, rq_full, rq_push;

  // ---------------- pending-load FIFO ----------------
  logic [2:0]     pl_f3  [DEPTH];
  logic [1:0]     pl_off [DEPTH];
  logic [RDW-1:0] pl_rd  [DEPTH];
  logic [AW-1:0]  pl_head, pl_tail;
  logic [CW-1:0]  pl_cnt;
  logic           pl_empty, pl_full, pl_push, pl_pop;

  logic           head_cmd, mem_fire;

  assign rq_empty = (rq_cnt == '0);
  assign rq_full  = (rq_cnt == FULL_CNT);
  assign pl_empty = (pl_cnt == '0);
  assign pl_full  = (pl_cnt == FULL_CNT);

  // Ready is forced low while reset is asserted.
  assign o_req_ready = aresetn && !rq_full;
  assign accept      = i_req_valid && o_req_ready;
  assign rq_push     = accept && !misaligned;

  assign head_cmd    = rq_cmd[rq_head];
  // A load may only issue if there is room to remember it.
  assign o_mem_valid = !rq_empty && (head_cmd || !pl_full);
  assign o_mem_cmd   = !rq_empty && head_cmd;
  assign o_mem_addr  = rq_empty ? 32'h0 : rq_addr[rq_head];
  assign o_mem_be    = rq_empty ? 4'h0  : rq_be[rq_head];
  assign o_mem_data  = rq_empty ? 32'h0 : rq_data[rq_head];

  assign mem_fire = o_mem_valid && i_mem_ready;
  assign pl_push  = mem_fire && !head_cmd;
  assign pl_pop   = i_mem_rvalid && !pl_empty;

  // ---------------- load formatting ----------------
  logic [15:0] ld_low;
  logic [31:0] ld_fmt;
  logic [2:0]  ld_f3;

  always_comb begin
    ld_f3  = pl_f3[pl_head];
    ld_low = 16'(i_mem_rdata >> {pl_off[pl_head], 3'b000});
    ld_fmt = i_mem_rdata;
    case (ld_f3[1:0])
      2'd0: ld_fmt = ld_f3[2] ? {24'b0, ld_low[7:0]} : {{24{ld_low[7]}}, ld_low[7:0]};
      2'd1: ld_fmt = ld_f3[2] ? {16'b0, ld_low} : {{16{ld_low[15]}}, ld_low};
      default: ld_fmt = i_mem_rdata;
    endcase
  end

  // ---------------- storage (no reset needed, guarded by counters) ----------------
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_cmd[rq_tail]  <= i_is_store;
      rq_addr[rq_tail] <= addr;
      rq_be[rq_tail]   <= be;
      rq_data[rq_tail] <= sdata;
      rq_f3[rq_tail]   <= i_funct3;
      rq_rd[rq_tail]   <= i_rd;
    end
    if (pl_push) begin
      pl_f3[pl_tail]  <= rq_f3[rq_head];
      pl_off[pl_tail] <= rq_addr[rq_head][1:0];
      pl_rd[pl_tail]  <= rq_rd[rq_head];
    end
  end

  // ---------------- control and registered outputs ----------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rq_head         <= '0;
      rq_tail         <= '0;
      rq_cnt          <= '0;
      pl_head         <= '0;
      pl_tail         <= '0;
      pl_cnt          <= '0;
      o_ld_valid      <= 1'b0;
      o_ld_data       <= '0;
      o_ld_rd         <= '0;
      o_misalign      <= 1'b0;
      o_misalign_addr <= '0;
    end else begin
      if (rq_push)  rq_tail <= rq_tail + 1'b1;
      if (mem_fire) rq_head <= rq_head + 1'b1;
      rq_cnt <= rq_cnt + CW'(rq_push) - CW'(mem_fire);

      if (pl_push) pl_tail <= pl_tail + 1'b1;
      if (pl_pop)  pl_head <= pl_head + 1'b1;
      pl_cnt <= pl_cnt + CW'(pl_push) - CW'(pl_pop);

      o_ld_valid <= pl_pop;
      if (pl_pop) begin
        o_ld_data <= ld_fmt;
        o_ld_rd   <= pl_rd[pl_head];
      end

      o_misalign <= accept && misaligned;
      if (accept && misaligned) o_misalign_addr <= addr;
    end
  end
endmodule
